// File: rtl/spmul_mac.sv
// spmul_mac: signed serial/parallel multiply-accumulate with scale, round and saturate
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   start      operation request, sampled only in IDLE
//   accum      with start: 0 = clear accumulator first, 1 = add onto held accumulator
//   sig_in     signed signal operand, sampled with start
//   coef_in    signed coefficient, sampled with start, consumed MSB first
//   busy       high while an operation is in progress
//   done       one-cycle pulse, result_out/sat valid
//   result_out scaled, rounded, saturated accumulator
//   sat        result_out was clipped (held until the next done)
module spmul_mac #(
    parameter int SIG_W     = 16,
    parameter int COEF_W    = 10,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 8,
    parameter int GUARD     = 4,
    parameter bit ROUND     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               accum,
    input  logic [SIG_W-1:0]   sig_in,
    input  logic [COEF_W-1:0]  coef_in,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   result_out,
    output logic               sat
);
    localparam int PROD_W  = SIG_W + COEF_W;
    localparam int ACC_W   = PROD_W + GUARD;
    localparam int CNT_W   = $clog2(COEF_W);
    localparam int RND_POS = OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0;
    localparam logic [ACC_W-1:0] RND = (ROUND && OUT_SHIFT > 0) ? ACC_W'(1) << RND_POS : '0;

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;

    state_t                   state, state_nx;
    logic signed [SIG_W-1:0]  sig_r;
    logic [COEF_W-1:0]        coef_r;
    logic                     accum_r;
    logic [CNT_W-1:0]         cnt;
    logic signed [PROD_W-1:0] prod, sig_x, term;
    logic signed [ACC_W-1:0]  acc, rsum, r;
    logic                     fit, last;

    assign busy  = state != IDLE;
    assign last  = cnt == CNT_W'(COEF_W - 1);
    assign sig_x = PROD_W'(sig_r);
    // the coefficient MSB carries negative weight in two's complement
    assign term  = !coef_r[COEF_W-1] ? '0 : (cnt == '0 ? -sig_x : sig_x);
    assign rsum  = acc + RND;
    assign r     = rsum >>> OUT_SHIFT;
    // r fits in OUT_W bits when all bits above the output sign bit match it
    assign fit   = &r[ACC_W-1:OUT_W-1] | ~|r[ACC_W-1:OUT_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? MUL : IDLE) :
                   state == MUL  ? (last ? ADD : MUL)   :
                   state == ADD  ? OUT : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r      <= '0;
            coef_r     <= '0;
            accum_r    <= 1'b0;
            cnt        <= '0;
            prod       <= '0;
            acc        <= '0;
            done       <= 1'b0;
            result_out <= '0;
            sat        <= 1'b0;
        end else begin
            done <= state == OUT;
            case (state)
                IDLE: if (start) begin
                    sig_r   <= sig_in;
                    coef_r  <= coef_in;
                    accum_r <= accum;
                    prod    <= '0;
                    cnt     <= '0;
                end
                MUL: begin
                    prod   <= (prod <<< 1) + term;
                    coef_r <= coef_r << 1;
                    cnt    <= cnt + 1'b1;
                end
                ADD: acc <= (accum_r ? acc : '0) + ACC_W'(prod);
                OUT: begin
                    result_out <= fit ? r[OUT_W-1:0] : {r[ACC_W-1], {(OUT_W-1){~r[ACC_W-1]}}};
                    sat        <= ~fit;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spmul_mac.sv
// tb_spmul_mac: self-checking bench for spmul_mac (rounding and truncating builds side by side)
module tb_spmul_mac;
    localparam int SIG_W  = 16;
    localparam int COEF_W = 10;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = SIG_W + COEF_W + 4;

    logic clk, rst, start, accum;
    logic [SIG_W-1:0]  sig_in;
    logic [COEF_W-1:0] coef_in;
    logic busy1, done1, sat1, busy0, done0, sat0;
    logic [OUT_W-1:0] res1, res0;

    spmul_mac #(.ROUND(1)) dut (
        .clk(clk), .rst(rst), .start(start), .accum(accum),
        .sig_in(sig_in), .coef_in(coef_in),
        .busy(busy1), .done(done1), .result_out(res1), .sat(sat1)
    );

    spmul_mac #(.ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .accum(accum),
        .sig_in(sig_in), .coef_in(coef_in),
        .busy(busy0), .done(done0), .result_out(res0), .sat(sat0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    longint m_acc = 0;
    longint e_r1, e_r0;
    bit e_s1, e_s0;
    int lat, bc;

    typedef struct {
        int s; int c; bit a;
        int r1; bit s1; int r0; bit s0;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint clip(input longint v, output bit s);
        s = v > 32767 || v < -32768;
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    task automatic run_op(input int s, input int c, input bit a);
        m_acc = wrap((a ? m_acc : 0) + longint'(s) * longint'(c), ACC_W);
        e_r1  = clip(wrap(m_acc + 128, ACC_W) >>> 8, e_s1);
        e_r0  = clip(m_acc >>> 8, e_s0);
        @(negedge clk);
        sig_in  = SIG_W'(s);
        coef_in = COEF_W'(c);
        accum   = a;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bc  = busy1 ? 1 : 0;
        lat = 0;
        while (!done1 && lat < 30) begin
            @(posedge clk);
            #1 lat++;
            if (busy1) bc++;
        end
    endtask

    initial begin
        tbl[0] = '{1000, 256, 1'b0, 1000, 1'b0, 1000, 1'b0};
        tbl[1] = '{-32768, -512, 1'b0, 32767, 1'b1, 32767, 1'b1};
        tbl[2] = '{-32768, 511, 1'b0, -32768, 1'b1, -32768, 1'b1};
        tbl[3] = '{3, 128, 1'b0, 2, 1'b0, 1, 1'b0};
        tbl[4] = '{-3, 128, 1'b0, -1, 1'b0, -2, 1'b0};
        tbl[5] = '{7, -1, 1'b0, 0, 1'b0, -1, 1'b0};
        tbl[6] = '{1000, 256, 1'b0, 1000, 1'b0, 1000, 1'b0};
        tbl[7] = '{500, -256, 1'b1, 500, 1'b0, 500, 1'b0};
        tbl[8] = '{-1, 256, 1'b1, 499, 1'b0, 499, 1'b0};

        rst = 1'b1; start = 1'b0; accum = 1'b0; sig_in = '0; coef_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_res", res1, 0);
        chk("rst_sat", sat1, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].s, tbl[i].c, tbl[i].a);
            chk($sformatf("tbl%0d_latency", i), lat, 12);
            chk($sformatf("tbl%0d_busy_cycles", i), bc, 12);
            chk($sformatf("tbl%0d_res_round", i), int'($signed(res1)), tbl[i].r1);
            chk($sformatf("tbl%0d_sat_round", i), sat1, tbl[i].s1);
            chk($sformatf("tbl%0d_res_trunc", i), int'($signed(res0)), tbl[i].r0);
            chk($sformatf("tbl%0d_sat_trunc", i), sat0, tbl[i].s0);
        end

        begin
            int dn[3];
            int k = 0, cyc = 0;
            dn = '{0, 0, 0};
            @(negedge clk);
            sig_in = 16'd1000; coef_in = 10'd256; accum = 1'b0; start = 1'b1;
            while (k < 3 && cyc < 60) begin
                @(posedge clk);
                #1 cyc++;
                if (done1) begin
                    dn[k] = cyc;
                    chk($sformatf("b2b_res%0d", k), int'($signed(res1)), 1000);
                    k++;
                    if (k == 3) start = 1'b0;
                    sig_in = 16'd1000; coef_in = 10'd256; accum = 1'b0;
                end else if (busy1) begin
                    sig_in = 16'($urandom); coef_in = 10'($urandom); accum = 1'b1;
                end
            end
            start = 1'b0;
            chk("b2b_count", k, 3);
            chk("b2b_gap1", dn[1] - dn[0], 13);
            chk("b2b_gap2", dn[2] - dn[1], 13);
            m_acc = 256000;
            repeat (2) @(posedge clk);
        end

        @(negedge clk);
        sig_in = 16'd1000; coef_in = 10'd256; accum = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_res", res1, 0);
        chk("abort_sat", sat1, 0);
        chk("abort_res_trunc", res0, 0);
        @(negedge clk) rst = 1'b0;
        m_acc = 0;
        run_op(1000, 256, 1'b1);
        chk("post_abort_latency", lat, 12);
        chk("post_abort_res", int'($signed(res1)), 1000);

        for (int i = 0; i < 150; i++) begin
            int s, c;
            bit a;
            s = int'($urandom_range(0, 65535)) - 32768;
            c = int'($urandom_range(0, 1023)) - 512;
            a = 1'($urandom_range(0, 1));
            run_op(s, c, a);
            chk($sformatf("rnd%0d_latency", i), lat, 12);
            chk($sformatf("rnd%0d_res_round(%0d*%0d,a=%0d)", i, s, c, a), int'($signed(res1)), e_r1);
            chk($sformatf("rnd%0d_sat_round", i), sat1, longint'(e_s1));
            chk($sformatf("rnd%0d_res_trunc", i), int'($signed(res0)), e_r0);
            chk($sformatf("rnd%0d_sat_trunc", i), sat0, longint'(e_s0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
